// File: rtl/mux8_scan_reader_pkg.sv
// rtl/mux8_scan_reader_pkg.sv - shared types, constants and helpers for the 8:1 selector scan reader
package mux8_scan_reader_pkg;

   localparam int SLOT_W    = 3;
   localparam int NUM_SLOTS = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

   // The selector decodes an inverted slot number.
   function automatic logic [SLOT_W-1:0] slot_to_sel_n(input logic [SLOT_W-1:0] slot);
      return ~slot;
   endfunction

endpackage

// File: rtl/mux8_scan_reader_settle_timer.sv
// rtl/mux8_scan_reader_settle_timer.sv - settle counter with terminal count at SETTLE_CYCLES-1
module mux8_scan_reader_settle_timer
   import mux8_scan_reader_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [7:0] TC_VAL = 8'(SETTLE_CYCLES - 1);

   logic [7:0] count;

   assign tc = (count == TC_VAL);

   // Count enabled cycles; wrap to zero at terminal count so the next slot starts fresh.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 8'd0;
      end else if (clr || (en && tc)) begin
         count <= 8'd0;
      end else if (en) begin
         count <= count + 8'd1;
      end
   end

endmodule

// File: rtl/mux8_scan_reader.sv
// rtl/mux8_scan_reader.sv - scans an 8:1 selector slot by slot and reassembles the switch byte
module mux8_scan_reader
   import mux8_scan_reader_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int CONTINUOUS    = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       y_in,
   output logic [2:0] sel_n,
   output logic       busy,
   output logic [7:0] data,
   output logic       valid,
   output logic       changed
);

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

   state_t            state;
   logic [SLOT_W-1:0] slot;
   logic [7:0]        shadow;
   logic [7:0]        shadow_next;
   logic              first;
   logic              tc;
   logic              timer_en;
   logic              timer_clr;

   // The timer only runs while a slot is settling; any other state parks it at zero.
   assign timer_en  = (state == SETTLE);
   assign timer_clr = (state != SETTLE);

   mux8_scan_reader_settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_timer (
      .clk (clk),
      .rst (rst),
      .clr (timer_clr),
      .en  (timer_en),
      .tc  (tc)
   );

   // Shadow with the current slot's bit replaced, so the final slot lands in data on the same edge.
   always_comb begin
      shadow_next       = shadow;
      shadow_next[slot] = y_in;
   end

   // Scan state machine; sel_n and busy are registered from the next state to keep outputs glitch-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         slot    <= '0;
         shadow  <= 8'h00;
         data    <= 8'h00;
         valid   <= 1'b0;
         changed <= 1'b0;
         first   <= 1'b1;
         busy    <= 1'b0;
         sel_n   <= 3'b111;
      end else begin
         valid   <= 1'b0;
         changed <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= SETTLE;
                  slot  <= '0;
                  busy  <= 1'b1;
                  sel_n <= slot_to_sel_n(3'd0);
               end
            end
            SETTLE: begin
               if (tc) begin
                  shadow <= shadow_next;
                  if (slot == LAST_SLOT) begin
                     data    <= shadow_next;
                     valid   <= 1'b1;
                     changed <= (shadow_next != data) | first;
                     first   <= 1'b0;
                     state   <= DONE;
                     sel_n   <= 3'b111;
                  end else begin
                     slot  <= slot + 3'd1;
                     sel_n <= slot_to_sel_n(slot + 3'd1);
                  end
               end
            end
            DONE: begin
               if (CONTINUOUS != 0) begin
                  state <= SETTLE;
                  slot  <= '0;
                  sel_n <= slot_to_sel_n(3'd0);
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  sel_n <= 3'b111;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               sel_n <= 3'b111;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux8_scan_reader.sv
// tb/tb_mux8_scan_reader.sv - self-checking bench for mux8_scan_reader
module tb_mux8_scan_reader;

   typedef struct {
      logic [7:0] a;
      logic [7:0] exp_data;
      logic       exp_changed;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_v   [3];
   logic [7:0] a_v       [3];
   logic [2:0] sel_v     [3];
   logic       busy_v    [3];
   logic       valid_v   [3];
   logic       changed_v [3];
   logic [7:0] data_v    [3];

   logic [2:0] sel0, sel1, sel2;
   logic       busy0, busy1, busy2;
   logic       valid0, valid1, valid2;
   logic       ch0, ch1, ch2;
   logic [7:0] data0, data1, data2;
   logic       y0, y1, y2;

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;

   logic [7:0] m_data  [3];
   logic       m_first [3];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Selector model: output is the switch bit chosen by the inverted select.
   always_comb begin
      y0 = a_v[0][~sel0];
      y1 = a_v[1][~sel1];
      y2 = a_v[2][~sel2];
   end

   always_comb begin
      sel_v[0] = sel0;     sel_v[1] = sel1;     sel_v[2] = sel2;
      busy_v[0] = busy0;   busy_v[1] = busy1;   busy_v[2] = busy2;
      valid_v[0] = valid0; valid_v[1] = valid1; valid_v[2] = valid2;
      changed_v[0] = ch0;  changed_v[1] = ch1;  changed_v[2] = ch2;
      data_v[0] = data0;   data_v[1] = data1;   data_v[2] = data2;
   end

   mux8_scan_reader #(.SETTLE_CYCLES(4), .CONTINUOUS(0)) dut_single (
      .clk(clk), .rst(rst), .start(start_v[0]), .y_in(y0), .sel_n(sel0),
      .busy(busy0), .data(data0), .valid(valid0), .changed(ch0));

   mux8_scan_reader #(.SETTLE_CYCLES(4), .CONTINUOUS(1)) dut_cont (
      .clk(clk), .rst(rst), .start(start_v[1]), .y_in(y1), .sel_n(sel1),
      .busy(busy1), .data(data1), .valid(valid1), .changed(ch1));

   mux8_scan_reader #(.SETTLE_CYCLES(1), .CONTINUOUS(0)) dut_fast (
      .clk(clk), .rst(rst), .start(start_v[2]), .y_in(y2), .sel_n(sel2),
      .busy(busy2), .data(data2), .valid(valid2), .changed(ch2));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_start(input int d, output int e0);
      @(negedge clk);
      start_v[d] = 1'b1;
      @(posedge clk);
      #1;
      start_v[d] = 1'b0;
      e0 = cyc;
   endtask

   task automatic wait_valid(input int d, input int max, output int at);
      at = -1;
      for (int k = 0; k < max; k++) begin
         @(posedge clk);
         #1;
         if (valid_v[d] === 1'b1) begin
            at = cyc;
            break;
         end
      end
   endtask

   // One start pulse; sel_n/busy are compared every cycle against slot = elapsed / S.
   task automatic run_scan(input int d, input int s, input logic [7:0] a,
                           output logic [7:0] got_d, output logic got_ch, output int lat,
                           output logic seq_ok, output logic fall_ok);
      int         e0;
      logic [2:0] exp_sel;
      a_v[d]  = a;
      seq_ok  = 1'b1;
      lat     = -1;
      got_d   = 8'hxx;
      got_ch  = 1'bx;
      pulse_start(d, e0);
      for (int n = 0; n < 400; n++) begin
         if (n > 0) begin
            @(posedge clk);
            #1;
         end
         exp_sel = (n < 8 * s) ? ~(3'(n / s)) : 3'b111;
         if (sel_v[d] !== exp_sel || busy_v[d] !== 1'b1) seq_ok = 1'b0;
         if (valid_v[d] === 1'b1) begin
            lat    = n;
            got_d  = data_v[d];
            got_ch = changed_v[d];
            break;
         end
      end
      @(posedge clk);
      #1;
      fall_ok = (busy_v[d] === 1'b0) && (valid_v[d] === 1'b0);
   endtask

   task automatic scan_and_check(input int d, input int s, input logic [7:0] a, input string tag);
      logic [7:0] gd;
      logic       gc, sq, fo;
      int         lat;
      run_scan(d, s, a, gd, gc, lat, sq, fo);
      check({tag, "_latency"}, lat, 8 * s);
      check({tag, "_data"}, gd, a);
      check({tag, "_changed"}, gc, m_first[d] || (a != m_data[d]));
      check({tag, "_sel_busy_seq"}, sq, 1'b1);
      check({tag, "_busy_fall"}, fo, 1'b1);
      m_data[d]  = a;
      m_first[d] = 1'b0;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       tbl [5];
      logic [7:0] gd;
      logic       gc, sq, fo, ok, found;
      int         lat, e0, t1, t2, t3;
      logic [7:0] ra;

      tbl[0] = '{a: 8'hA5, exp_data: 8'hA5, exp_changed: 1'b1};
      tbl[1] = '{a: 8'hA5, exp_data: 8'hA5, exp_changed: 1'b0};
      tbl[2] = '{a: 8'h5A, exp_data: 8'h5A, exp_changed: 1'b1};
      tbl[3] = '{a: 8'h00, exp_data: 8'h00, exp_changed: 1'b1};
      tbl[4] = '{a: 8'h00, exp_data: 8'h00, exp_changed: 1'b0};

      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         a_v[i]     = 8'h00;
         m_data[i]  = 8'h00;
         m_first[i] = 1'b1;
      end

      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_sel_n", sel_v[0], 3'b111);
      check("reset_busy", busy_v[0], 1'b0);
      check("reset_data", data_v[0], 8'h00);
      check("reset_valid", valid_v[0], 1'b0);
      check("reset_changed", changed_v[0], 1'b0);

      ok = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         #1;
         if (sel_v[0] !== 3'b111 || busy_v[0] !== 1'b0 || data_v[0] !== 8'h00 || valid_v[0] !== 1'b0)
            ok = 1'b0;
      end
      check("idle_100_cycles", ok, 1'b1);

      for (int i = 0; i < 5; i++) begin
         run_scan(0, 4, tbl[i].a, gd, gc, lat, sq, fo);
         check($sformatf("tbl%0d_latency", i), lat, 32);
         check($sformatf("tbl%0d_data", i), gd, tbl[i].exp_data);
         check($sformatf("tbl%0d_changed", i), gc, tbl[i].exp_changed);
         check($sformatf("tbl%0d_sel_busy_seq", i), sq, 1'b1);
         check($sformatf("tbl%0d_busy_fall", i), fo, 1'b1);
         m_data[0]  = tbl[i].a;
         m_first[0] = 1'b0;
      end

      a_v[1] = 8'h3C;
      pulse_start(1, e0);
      wait_valid(1, 100, t1);
      check("cont_first_latency", t1 - e0, 32);
      check("cont1_data", data_v[1], 8'h3C);
      check("cont1_changed", changed_v[1], 1'b1);
      check("cont_done_sel_n", sel_v[1], 3'b111);
      wait_valid(1, 100, t2);
      check("cont_period_1", t2 - t1, 33);
      check("cont2_data", data_v[1], 8'h3C);
      check("cont2_changed", changed_v[1], 1'b0);
      a_v[1] = 8'hC3;
      wait_valid(1, 100, t3);
      check("cont_period_2", t3 - t2, 33);
      check("cont3_data", data_v[1], 8'hC3);
      check("cont3_changed", changed_v[1], 1'b1);

      a_v[0] = 8'h69;
      @(negedge clk);
      start_v[0] = 1'b1;
      wait_valid(0, 100, t1);
      check("hold1_data", data_v[0], 8'h69);
      check("hold1_changed", changed_v[0], 1'b1);
      wait_valid(0, 100, t2);
      check("hold_rearm_period", t2 - t1, 34);
      check("hold2_data", data_v[0], 8'h69);
      check("hold2_changed", changed_v[0], 1'b0);
      @(posedge clk);
      #1;
      check("start_in_done_ignored_busy", busy_v[0], 1'b0);
      check("start_in_done_valid_low", valid_v[0], 1'b0);
      start_v[0] = 1'b0;
      ok = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         #1;
         if (valid_v[0] !== 1'b0 || busy_v[0] !== 1'b0) ok = 1'b0;
      end
      check("stay_idle_after_done", ok, 1'b1);
      m_data[0]  = 8'h69;
      m_first[0] = 1'b0;

      a_v[0] = 8'hFF;
      pulse_start(0, e0);
      found = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (sel_v[0] === 3'b010) begin
            found = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      check("reach_slot5", found, 1'b1);
      #3;
      rst = 1'b1;
      #1;
      check("midrst_sel_n", sel_v[0], 3'b111);
      check("midrst_busy", busy_v[0], 1'b0);
      check("midrst_data", data_v[0], 8'h00);
      check("midrst_valid", valid_v[0], 1'b0);
      check("midrst_changed", changed_v[0], 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         m_data[i]  = 8'h00;
         m_first[i] = 1'b1;
      end
      ok = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (valid_v[0] !== 1'b0 || busy_v[0] !== 1'b0) ok = 1'b0;
      end
      check("no_valid_after_abort", ok, 1'b1);
      scan_and_check(0, 4, 8'hFF, "post_rst");

      scan_and_check(2, 1, 8'h01, "s1_bit0");
      scan_and_check(2, 1, 8'h80, "s1_bit7");

      for (int i = 0; i < 10; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? m_data[0] : 8'($urandom);
         scan_and_check(0, 4, ra, $sformatf("rand%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
